// File: rtl/buzzer_pkg.sv
// Shared types and note tables for the buzzer tone generator.
// Holds the FSM state enum, note indices and divisor helper.
package buzzer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        REST
    } state_t;

    localparam logic [3:0] NOTE_C4   = 4'd0;
    localparam logic [3:0] NOTE_D4   = 4'd1;
    localparam logic [3:0] NOTE_E4   = 4'd2;
    localparam logic [3:0] NOTE_F4   = 4'd3;
    localparam logic [3:0] NOTE_G4   = 4'd4;
    localparam logic [3:0] NOTE_A4   = 4'd5;
    localparam logic [3:0] NOTE_B4   = 4'd6;
    localparam logic [3:0] NOTE_C5   = 4'd7;
    localparam logic [3:0] NOTE_D5   = 4'd8;
    localparam logic [3:0] NOTE_E5   = 4'd9;
    localparam logic [3:0] NOTE_F5   = 4'd10;
    localparam logic [3:0] NOTE_G5   = 4'd11;
    localparam logic [3:0] NOTE_A5   = 4'd12;
    localparam logic [3:0] NOTE_B5   = 4'd13;
    localparam logic [3:0] NOTE_C6   = 4'd14;
    localparam logic [3:0] NOTE_REST = 4'd15;

    // Nominal note frequencies in centi-Hz (rounded), C4..C6.
    localparam int unsigned NOTE_CHZ [15] = '{
        26163, 29366, 32963, 34923, 39200, 44000, 49388,
        52325, 58733, 65926, 69846, 78399, 88000, 98777,
        104650
    };

    // Semitone offset of each diatonic index from C4.
    localparam int NOTE_SEMI [15] = '{
        0, 2, 4, 5, 7, 9, 11, 12, 14, 16, 17, 19, 21, 23, 24
    };

    // Half-period in clocks, computed from the exact tempered
    // frequency so large CLK_HZ values keep full precision.
    function automatic int half_per_calc(
        input int clk_hz,
        input int idx,
        input int div_w
    );
        real f_hz;
        real hp_r;
        int  hp;
        int  hp_max;
        if (idx < 0 || idx > 14) begin
            return 0;
        end
        hp_max = (div_w >= 31) ? 32'h7fff_ffff
                               : (1 << div_w) - 1;
        f_hz = 440.0 *
            (2.0 ** (real'(NOTE_SEMI[idx] - 9) / 12.0));
        hp_r = real'(clk_hz) / (2.0 * f_hz);
        hp   = $rtoi(hp_r + 0.5);
        if (hp > hp_max) hp = hp_max;
        if (hp < 2) hp = 2;
        return hp;
    endfunction

endpackage

// File: rtl/note_divider_rom.sv
// Note index to half-period divisor, built at elaboration.
// Ports: key (note index) -> half_per (clocks per half cycle).
module note_divider_rom
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int DIV_W  = 18
) (
    input  logic [3:0]       key,
    output logic [DIV_W-1:0] half_per
);

    logic [DIV_W-1:0] rom [16];

    // Index 15 (rest) yields 0; it is never loaded.
    for (genvar i = 0; i < 16; i++) begin : g_rom
        localparam int HP = half_per_calc(CLK_HZ, i, DIV_W);
        assign rom[i] = HP[DIV_W-1:0];
    end

    assign half_per = rom[key];

endmodule

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver gated by a song player's note.
// Ports: clk, rst_n, key_on, key, mute -> speaker, sounding, note_q.
module buzzer_tone_gen
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int DIV_W  = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_on,
    input  logic [3:0] key,
    input  logic       mute,
    output logic       speaker,
    output logic       sounding,
    output logic [3:0] note_q
);

    state_t           state;
    state_t           state_d;
    logic             key_on_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] half_per;
    logic [DIV_W-1:0] half_d;
    logic [DIV_W-1:0] rom_half;
    logic             phase;
    logic             phase_d;
    logic [3:0]       note_d;
    logic             rise;

    note_divider_rom #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) u_rom (
        .key      (key),
        .half_per (rom_half)
    );

    assign rise = key_on & ~key_on_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_on_q <= 1'b0;
            cnt      <= '0;
            half_per <= '0;
            phase    <= 1'b0;
            note_q   <= '0;
        end else begin
            state    <= state_d;
            key_on_q <= key_on;
            cnt      <= cnt_d;
            half_per <= half_d;
            phase    <= phase_d;
            note_q   <= note_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        half_d  = half_per;
        phase_d = phase;
        note_d  = note_q;
        if (rise) begin
            note_d  = key;
            cnt_d   = '0;
            phase_d = 1'b0;
            if (key == NOTE_REST) begin
                state_d = REST;
            end else begin
                state_d = PLAY;
                half_d  = rom_half;
            end
        end else if (!key_on) begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (state == PLAY) begin
            if (cnt == half_per - 1'b1) begin
                cnt_d   = '0;
                phase_d = ~phase;
            end else begin
                cnt_d = cnt + 1'b1;
            end
        end
    end

    // Mute only masks the output; phase keeps running underneath.
    assign speaker  = phase & ~mute;
    assign sounding = (state == PLAY);

endmodule

// File: doc/buzzer_tone_gen.md
BUZZER_TONE_GEN -- requirements
Module: buzzer_tone_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter DIV_W, default 18, width of the half-period divisor and phase counter.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port key_on  input  1  note gate from the upstream song player; high while the note sounds.
REQ-006 SHALL have port key  input  4  note index; 0..14 = C4..C6 diatonic (7 indices per octave); 15 = rest.
REQ-007 SHALL have port mute  input  1  forces speaker low without disturbing tone timing.
REQ-008 SHALL have port speaker  output  1  square-wave drive to the buzzer.
REQ-009 SHALL have port sounding  output  1  high while in PLAY state.
REQ-010 SHALL have port note_q  output  4  note index latched for the current or last note.

Function
REQ-011 SHALL register key_on into key_on_q each cycle and detect a rising edge as key_on=1 and key_on_q=0.
REQ-012 SHALL implement states IDLE, PLAY and REST.
REQ-013 Transition rule: on a rising edge with key!=15, SHALL latch key into note_q, load half_per from the divisor table, clear cnt, drive speaker=0 and enter PLAY on the next edge.
REQ-014 Transition rule: on a rising edge with key==15, SHALL latch note_q=15 and enter REST with speaker=0.
REQ-015 In PLAY, cnt SHALL increment every cycle; when cnt==half_per-1, speaker SHALL toggle and cnt SHALL return to 0.
REQ-016 Timing consequence of REQ-013/REQ-015: for a rising edge seen at cycle N, the first speaker 0->1 transition SHALL occur at cycle N+1+half_per.
REQ-017 Divisor rule: half_per SHALL equal round(CLK_HZ/(2*f_note)), with f_note from equal temperament A4=440 Hz. Values at 100 MHz include C4=191113, A4=113636 and C6=47778.
REQ-018 Any half_per greater than 2^DIV_W-1 SHALL saturate to 2^DIV_W-1.
REQ-019 Any half_per below 2 SHALL be clamped to 2.
REQ-020 While key_on stays high, changes on key SHALL be ignored; a new note is taken only on the next rising edge.
REQ-021 On key_on=0 in PLAY or REST, the block SHALL enter IDLE on the next edge; speaker=0 and cnt=0 in IDLE.
REQ-022 A one-cycle key_on pulse SHALL start a note, and the block SHALL return to IDLE one cycle later.
REQ-023 With mute=1, speaker SHALL be 0 while cnt and the internal phase continue. On mute release, speaker SHALL resume with the current internal phase.
REQ-024 sounding SHALL be 1 only in PLAY.
REQ-025 note_q SHALL hold its value through IDLE until the next rising edge.

Reset
REQ-026 With rst_n=0 at a posedge, the block SHALL set state=IDLE, speaker=0, sounding=0, note_q=0, cnt=0, half_per=0 and key_on_q=0.
REQ-027 Reset asserted mid-note SHALL silence speaker at the same edge; no partial period continues after reset.
REQ-028 If key_on is already high when rst_n releases, the block SHALL treat it as a rising edge and start the note.

Structure
REQ-029 Package buzzer_pkg SHALL hold the state enum, the note index constants (NOTE_C4..NOTE_C6, NOTE_REST=15) and the note frequency table in centi-Hz.
REQ-030 Sub-module note_divider_rom (combinational: key -> half_per, computed from CLK_HZ at elaboration) SHALL be instantiated once.

Verification (bench SHALL run with CLK_HZ=1_000_000 to shorten simulation; the values below correspond to that setting)
REQ-031 Reset, then key=5 with key_on rising and held -> half_per=1136, first speaker rise 1137 cycles after the edge, period 2272 cycles, sounding=1.
REQ-032 During the REQ-031 note, change key to 0 mid-note with key_on held high -> period stays 2272; note_q stays 5.
REQ-033 Drop key_on, then raise it with key=15 -> IDLE then REST, speaker=0 throughout, sounding=0, note_q=15.
REQ-034 Pulse mute for 3000 cycles during key=7 -> speaker=0 during the pulse; phase after release matches an unmuted reference run.
REQ-035 Assert rst_n=0 mid-note while speaker=1 -> speaker=0, note_q=0 and state IDLE at the same edge.
REQ-036 Hold key_on=1 through reset release with key=14 -> note starts, half_per=478, first rise at cycle N+479.
